// File: rtl/sys_timer_intc.sv
// sys_timer_intc: bank of programmable down-counters plus external interrupt
// sources, each with pending and mask bits, aggregated into the core's 6-bit
// interrupt vector. Slave on the data-memory bus (ce/we/addr/dataIn/dataOut).
module sys_timer_intc #(
    parameter int          NUM_TIMERS = 2,
    parameter int          NUM_EXT    = 4,
    parameter int          CNT_WIDTH  = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic               we,
    input  logic [31:0]        addr,
    input  logic [31:0]        dataIn,
    output logic [31:0]        dataOut,
    input  logic [NUM_EXT-1:0] ext_irq,
    output logic [5:0]         intr
);

    localparam int                   NUM_SRC  = NUM_TIMERS + NUM_EXT;
    // Implemented source bits; everything above reads 0 and never asserts.
    localparam logic [5:0]           SRC_MASK = 6'b111111 >> (6 - NUM_SRC);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                  sel_s;
    logic                  wr_s;
    logic [7:0]            off_s;
    logic                  unused_s;

    logic [5:0]            pend_r, pend_n;
    logic [5:0]            mask_r, mask_n;
    logic [5:0]            set_s;
    logic [5:0]            intr_r;
    logic [NUM_EXT-1:0]    ext_mode_r, ext_mode_n;
    logic [NUM_EXT-1:0]    sync1_r, sync2_r, sync3_r;

    logic [NUM_TIMERS-1:0] en_r, en_n;
    logic [NUM_TIMERS-1:0] auto_r, auto_n;
    logic [NUM_TIMERS-1:0] expire_s;
    logic [NUM_TIMERS-1:0] ctrl_wr_s;
    logic [NUM_TIMERS-1:0] load_wr_s;
    logic [CNT_WIDTH-1:0]  load_r [NUM_TIMERS];
    logic [CNT_WIDTH-1:0]  load_n [NUM_TIMERS];
    logic [CNT_WIDTH-1:0]  cnt_r  [NUM_TIMERS];
    logic [CNT_WIDTH-1:0]  cnt_n  [NUM_TIMERS];
    logic [31:0]           tmr_rd_s [NUM_TIMERS];
    logic [31:0]           rdata_s;

    // Word-aligned decode: the two low address bits never take part.
    assign sel_s    = ce && (addr[31:8] == BASE_ADDR[31:8]);
    assign wr_s     = sel_s && we;
    assign off_s    = {addr[7:2], 2'b00};
    assign unused_s = ^{addr[1:0], dataIn};

    // Timer channels: count down, expire, reload or stop, and bus CTRL/LOAD writes.
    always_comb begin
        set_s = 6'h00;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            ctrl_wr_s[i] = wr_s && (off_s[7:4] == 4'(i + 1)) && (off_s[3:0] == 4'h0);
            load_wr_s[i] = wr_s && (off_s[7:4] == 4'(i + 1)) && (off_s[3:0] == 4'h4);
            expire_s[i]  = en_r[i] && (cnt_r[i] == CNT_ZERO);
            set_s[i]     = expire_s[i];

            // Enabling from idle loads COUNT and skips the decrement that cycle.
            if (ctrl_wr_s[i] && dataIn[0] && !en_r[i]) begin
                cnt_n[i] = load_r[i];
            end else if (en_r[i] && !expire_s[i]) begin
                cnt_n[i] = cnt_r[i] - CNT_ONE;
            end else if (expire_s[i] && auto_r[i]) begin
                cnt_n[i] = load_r[i];
            end else begin
                cnt_n[i] = cnt_r[i];
            end

            // A bus CTRL write overrides the one-shot self-disable.
            if (ctrl_wr_s[i]) begin
                en_n[i]   = dataIn[0];
                auto_n[i] = dataIn[1];
            end else if (expire_s[i] && !auto_r[i]) begin
                en_n[i]   = 1'b0;
                auto_n[i] = auto_r[i];
            end else begin
                en_n[i]   = en_r[i];
                auto_n[i] = auto_r[i];
            end

            if (load_wr_s[i]) begin
                load_n[i] = dataIn[CNT_WIDTH-1:0];
            end else begin
                load_n[i] = load_r[i];
            end
        end

        // External sources: rising edge or level of the synchronised line.
        for (int k = 0; k < NUM_EXT; k++) begin
            set_s[NUM_TIMERS + k] = ext_mode_r[k] ? (sync2_r[k] & ~sync3_r[k]) : sync2_r[k];
        end
    end

    // Pending (W1C, set wins), mask and ext-mode register next state.
    always_comb begin
        if (wr_s && (off_s == 8'h00)) begin
            pend_n = ((pend_r & ~dataIn[5:0]) | set_s) & SRC_MASK;
        end else begin
            pend_n = (pend_r | set_s) & SRC_MASK;
        end

        if (wr_s && (off_s == 8'h04)) begin
            mask_n = dataIn[5:0] & SRC_MASK;
        end else begin
            mask_n = mask_r;
        end

        if (wr_s && (off_s == 8'h08)) begin
            ext_mode_n = dataIn[NUM_EXT-1:0];
        end else begin
            ext_mode_n = ext_mode_r;
        end
    end

    // State registers, synchronisers and the registered interrupt vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r     <= 6'h00;
            mask_r     <= 6'h00;
            intr_r     <= 6'h00;
            ext_mode_r <= {NUM_EXT{1'b0}};
            sync1_r    <= {NUM_EXT{1'b0}};
            sync2_r    <= {NUM_EXT{1'b0}};
            sync3_r    <= {NUM_EXT{1'b0}};
            en_r       <= {NUM_TIMERS{1'b0}};
            auto_r     <= {NUM_TIMERS{1'b0}};
            for (int i = 0; i < NUM_TIMERS; i++) begin
                load_r[i] <= CNT_ZERO;
                cnt_r[i]  <= CNT_ZERO;
            end
        end else begin
            pend_r     <= pend_n;
            mask_r     <= mask_n;
            // Registered from next-state so intr rises on the same edge as PEND.
            intr_r     <= pend_n & mask_n;
            ext_mode_r <= ext_mode_n;
            sync1_r    <= ext_irq;
            sync2_r    <= sync1_r;
            sync3_r    <= sync2_r;
            en_r       <= en_n;
            auto_r     <= auto_n;
            for (int i = 0; i < NUM_TIMERS; i++) begin
                load_r[i] <= load_n[i];
                cnt_r[i]  <= cnt_n[i];
            end
        end
    end

    // Per-timer read value, zero when the offset belongs to another channel.
    always_comb begin
        for (int i = 0; i < NUM_TIMERS; i++) begin
            if (off_s[7:4] == 4'(i + 1)) begin
                case (off_s[3:0])
                    4'h0:    tmr_rd_s[i] = {30'h0, auto_r[i], en_r[i]};
                    4'h4:    tmr_rd_s[i] = 32'(load_r[i]);
                    4'h8:    tmr_rd_s[i] = 32'(cnt_r[i]);
                    default: tmr_rd_s[i] = 32'h0;
                endcase
            end else begin
                tmr_rd_s[i] = 32'h0;
            end
        end
    end

    // Combinational read mux; zero when unselected, writing or unmapped.
    always_comb begin
        rdata_s = 32'h0;
        if (sel_s && !we) begin
            case (off_s)
                8'h00:   rdata_s = 32'(pend_r);
                8'h04:   rdata_s = 32'(mask_r);
                8'h08:   rdata_s = 32'(ext_mode_r);
                default: begin
                    for (int i = 0; i < NUM_TIMERS; i++) begin
                        rdata_s = rdata_s | tmr_rd_s[i];
                    end
                end
            endcase
        end else begin
            rdata_s = 32'h0;
        end
    end

    assign dataOut = rdata_s;
    assign intr    = intr_r;

endmodule

// File: doc/sys_timer_intc.md
# sys_timer_intc

Parametrised timer bank and interrupt aggregator on the SoC data-memory bus, producing the core's 6-bit `intr` vector. It replaces the hardwired `{5'b0, intimer}` tie-off with N programmable down-counters plus M external sources. Every source has its own pending and mask bits. It is a bus slave decoded alongside the data memory, using the same `ce`/`we`/`addr`/`dataIn`/`dataOut` convention.

## Interface
- `NUM_TIMERS`, 2: number of timer channels, 1..6.
- `NUM_EXT`, 4: number of external interrupt inputs. `NUM_TIMERS + NUM_EXT` ≤ 6.
- `CNT_WIDTH`, 32: counter and LOAD width, 8..32. Reads are zero-extended to 32 bits.
- `BASE_ADDR`, 32'h0000_1000: block base address, 256-byte aligned.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous reset, active-high.
- `ce`  in  1  bus chip enable.
- `we`  in  1  write enable, qualified by `ce`.
- `addr`  in  32  byte address. Word-aligned; `addr[1:0]` is ignored.
- `dataIn`  in  32  write data.
- `dataOut`  out  32  read data. Combinational.
- `ext_irq`  in  NUM_EXT  external interrupt lines. Asynchronous to `clk`.
- `intr`  out  6  interrupt vector to the core.

## Operation
- Decode: the block is selected when `ce` is high and `addr[31:8] == BASE_ADDR[31:8]`. Offset is `addr[7:0]`.
- Register map:
  - 0x00 PEND: read returns pending bits. Write-1-to-clear.
  - 0x04 MASK: read/write.
  - 0x08 EXT_MODE: bit k = 1 selects rising-edge mode for ext k; 0 selects level mode.
  - Timer i at 0x10+0x10·i:
    - +0 CTRL: bit0 EN, bit1 AUTO (auto-reload). Read/write.
    - +4 LOAD: read/write.
    - +8 COUNT: read-only.
- Source numbering:
  - Timer i maps to source bit i. Timer 0 is bit 0, the former `intimer` position.
  - Ext k maps to source bit `NUM_TIMERS + k`.
  - Bits at or above `NUM_TIMERS + NUM_EXT` read 0, ignore writes, and drive `intr` 0.
- Timer, per cycle:
  - EN = 0: COUNT holds.
  - EN = 1 and COUNT ≠ 0: COUNT decrements by 1.
  - EN = 1 and COUNT = 0 (expiry): PEND[i] is set.
    - AUTO = 1: COUNT is reloaded from LOAD.
    - AUTO = 0: EN clears and COUNT stays 0.
  - A CTRL write that takes EN from 0 to 1 loads COUNT from LOAD; no decrement occurs that cycle.
  - A LOAD write does not touch COUNT.
  - The period is LOAD+1 cycles. LOAD = 0 with AUTO = 1 expires every cycle.
- External inputs:
  - Each input passes through a 2-flop synchroniser. A third flop provides edge detection.
  - Edge mode: a synchronised 0→1 transition sets PEND.
  - Level mode: PEND is set every cycle the synchronised level is 1, so a W1C clear is ineffective while the line stays high.
- `intr[j] = PEND[j] & MASK[j]`. Output from registers only; no combinational path from the bus.
- Reads:
  - `dataOut` is the addressed register when selected and `we` = 0.
  - Otherwise `dataOut` is 0, including unmapped offsets.
  - Writes to unmapped or read-only offsets have no effect.

## Timing
- Reset (`rst` high at a `clk` edge):
  - PEND, MASK, EXT_MODE, all CTRL, LOAD and COUNT go to 0.
  - Synchroniser flops go to 0.
  - `intr` = 0. `dataOut` = 0 while unselected.
  - Reset mid-count aborts the count with no pending set.
- Register writes take effect at the `clk` edge where selected and `we` are high. A read in the next cycle returns the new value.
- Timer expiry latency: with EN = 1 and COUNT = 0 at edge t, PEND[i] is set at edge t. `intr[i]` is high from edge t, if masked in.
- External latency: an ext edge stable before edge t sets PEND at edge t+2. `intr` follows PEND in the same cycle.
- Simultaneous events:
  - A W1C on PEND[j] in the same cycle as a set event for j: set wins, and the bit stays 1.
  - A bus CTRL write in the same cycle as an expiry: the written EN/AUTO values win, but PEND is still set.
  - A bus CTRL write taking EN 0→1 in the same cycle as an expiry on that timer: COUNT loads from LOAD.
- MASK affects only `intr`. Masked sources still accumulate PEND.

## Test plan
- Reset check: hold `rst` for 3 cycles with random bus traffic. Then every register reads 0 and `intr` = 6'b0.
- Auto-reload timer 0:
  - Stimulus: LOAD = 4, MASK = 1, CTRL = 3.
  - Required: `intr[0]` rises 5 cycles after the CTRL write edge. A W1C of PEND = 1 clears it. It re-asserts 5 cycles after the previous expiry.
- One-shot timer 1:
  - Stimulus: LOAD = 2, CTRL = 1.
  - Required: a single expiry at the 3rd edge after the write. CTRL then reads 0 and COUNT reads 0, and PEND[1] is never set again.
- External edge vs level (NUM_TIMERS = 2):
  - Edge mode: a pulse on `ext_irq[0]` sets PEND[2] exactly 2 edges later, and W1C clears it with the line still high.
  - Level mode: with `ext_irq[1]` held high, PEND[3] stays 1 despite W1C.
- Collision: W1C of PEND[0] timed on the exact expiry cycle (LOAD = 0, AUTO = 1) leaves PEND[0] = 1.
- Decode: a read at BASE_ADDR + 0xFC, or at an address outside the base, returns 0. A write of 0xFFFFFFFF to PEND offset 0x00 with MASK = 0 leaves `intr` = 0. A write of 0xFFFFFFFF to MASK reads back only the implemented bits (6'b111111 for default parameters).
